// File: rtl/exe_mdu_if.sv
// EXE-stage multiply/divide unit port bundle: operands and opcode in, HI/LO and stall out.
// The pipeline side drives through master; the MDU itself attaches through slave.
interface exe_mdu_if;
  logic [2:0]  EXE_MDUOp;
  logic        EXE_Valid;
  logic [31:0] EXE_OutA;
  logic [31:0] EXE_OutB;
  logic        EXEMEM_Flush;
  logic        EXE_MDUStall;
  logic [31:0] EXE_HI;
  logic [31:0] EXE_LO;
  logic        MDU_Busy;

  modport master (
    output EXE_MDUOp, EXE_Valid, EXE_OutA, EXE_OutB, EXEMEM_Flush,
    input  EXE_MDUStall, EXE_HI, EXE_LO, MDU_Busy
  );

  modport slave (
    input  EXE_MDUOp, EXE_Valid, EXE_OutA, EXE_OutB, EXEMEM_Flush,
    output EXE_MDUStall, EXE_HI, EXE_LO, MDU_Busy
  );
endinterface

// File: rtl/exe_mdu.sv
// HI/LO owner: MULT*/MT* write in 1 cycle; DIV* is a 32-step restoring divide (stall held 33 cycles).
// Backpressure: EXE_MDUStall holds the front end while a divide is accepted or running; flush drops it at once.
module exe_mdu #(
  parameter int DIV_ITER = 32
) (
  input  logic     clk,
  input  logic     rst,
  exe_mdu_if.slave mdu
);

  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITER - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]   r_hi, r_lo;
  logic [31:0]   r_quo, r_rem, r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_qsign, r_rsign, r_dz;

  logic          w_is_div, w_is_sdiv, w_accept;
  logic [63:0]   w_ext_a, w_ext_b, w_prod;
  logic [31:0]   w_abs_a, w_abs_b;
  logic [32:0]   w_rem_sh;
  logic [31:0]   w_diff, w_rem_nxt;
  logic          w_ge;
  logic [31:0]   w_quo_fin, w_rem_fin;

  assign w_is_div  = (mdu.EXE_MDUOp == OP_DIV) || (mdu.EXE_MDUOp == OP_DIVU);
  assign w_is_sdiv = (mdu.EXE_MDUOp == OP_DIV);
  assign w_accept  = mdu.EXE_Valid && !mdu.EXEMEM_Flush && (r_state == S_IDLE);

  // Truncating the 64x64 product to 64 bits is exact for both signed and unsigned forms.
  assign w_ext_a = (mdu.EXE_MDUOp == OP_MULT) ? {{32{mdu.EXE_OutA[31]}}, mdu.EXE_OutA}
                                               : {32'd0, mdu.EXE_OutA};
  assign w_ext_b = (mdu.EXE_MDUOp == OP_MULT) ? {{32{mdu.EXE_OutB[31]}}, mdu.EXE_OutB}
                                               : {32'd0, mdu.EXE_OutB};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_abs_a = (w_is_sdiv && mdu.EXE_OutA[31]) ? (32'd0 - mdu.EXE_OutA) : mdu.EXE_OutA;
  assign w_abs_b = (w_is_sdiv && mdu.EXE_OutB[31]) ? (32'd0 - mdu.EXE_OutB) : mdu.EXE_OutB;

  // Shifted partial remainder needs a 33rd bit once the divisor exceeds 2^31.
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff    = w_rem_sh[31:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_diff : w_rem_sh[31:0];

  assign w_quo_fin = r_qsign ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fin = r_rsign ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (mdu.EXEMEM_Flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (mdu.EXE_Valid && w_is_div) w_next = S_RUN;
        S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mdu.EXE_MDUStall = 1'b0;
    mdu.MDU_Busy     = (r_state != S_IDLE);
    if (!mdu.EXEMEM_Flush) begin
      mdu.EXE_MDUStall = ((r_state == S_IDLE) && mdu.EXE_Valid && w_is_div) ||
                         (r_state == S_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept && w_is_div) begin
      r_quo   <= w_abs_a;
      r_dvs   <= w_abs_b;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_qsign <= w_is_sdiv && (mdu.EXE_OutA[31] ^ mdu.EXE_OutB[31]);
      r_rsign <= w_is_sdiv && mdu.EXE_OutA[31];
      r_dz    <= (mdu.EXE_OutB == 32'd0);
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_nxt;
      r_quo <= {r_quo[30:0], w_ge};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept) begin
      unique case (mdu.EXE_MDUOp)
        OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod;
        OP_MTHI:           r_hi <= mdu.EXE_OutA;
        OP_MTLO:           r_lo <= mdu.EXE_OutA;
        default:           ;
      endcase
    end else if ((r_state == S_DONE) && !mdu.EXEMEM_Flush && !r_dz) begin
      r_lo <= w_quo_fin;
      r_hi <= w_rem_fin;
    end
  end

  assign mdu.EXE_HI = r_hi;
  assign mdu.EXE_LO = r_lo;

endmodule

// File: tb/tb_exe_mdu.sv
// Self-checking bench for exe_mdu: directed vector table, flush/reset sequences, random ops vs a model.
module tb_exe_mdu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_mdu_if bus();
  exe_mdu #(.DIV_ITER(32)) dut (.clk(clk), .rst(rst), .mdu(bus.slave));

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural HI/LO.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int exp_st);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_st = 0;
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: begin
        exp_st = 33;
        if (b != 32'd0) begin
          q = sa / sb; r = sa % sb;
          m_lo = 32'(q); m_hi = 32'(r);
        end
      end
      3'd4: begin
        exp_st = 33;
        if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Presents one instruction; it stays in EXE while stall is high, then leaves at the next edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int st, output bit timeout);
    bit done;
    bus.EXE_Valid = 1'b1;
    bus.EXE_MDUOp = op;
    bus.EXE_OutA  = a;
    bus.EXE_OutB  = b;
    st = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.EXE_MDUStall) st++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.EXE_Valid = 1'b0;
    bus.EXE_MDUOp = 3'd0;
    timeout = !done;
  endtask

  task automatic op_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] ehi,
                              input logic [31:0] elo, input int est);
    int st;
    bit to;
    run_op(op, a, b, st, to);
    chk({tag, "_timeout"}, 64'(to), 64'd0);
    chk({tag, "_stall_cycles"}, 64'(st), 64'(est));
    chk({tag, "_hi"}, 64'(bus.EXE_HI), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.EXE_LO), 64'(elo));
    chk({tag, "_busy"}, 64'(bus.MDU_Busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[$];

  initial begin
    int st;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    bus.EXE_MDUOp = 3'd0;
    bus.EXE_Valid = 1'b0;
    bus.EXE_OutA = 32'd0;
    bus.EXE_OutB = 32'd0;
    bus.EXEMEM_Flush = 1'b0;

    vt.push_back('{3'd1, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 0});
    vt.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 0});
    vt.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vt.push_back('{3'd4, 32'd100,       32'd7,          32'd2,         32'd14,        33});
    vt.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 33});
    vt.push_back('{3'd5, 32'h11,        32'd0,          32'h11,        32'h8000_0000, 0});
    vt.push_back('{3'd6, 32'h22,        32'd0,          32'h11,        32'h22,        0});
    vt.push_back('{3'd4, 32'd5,         32'd0,          32'h11,        32'h22,        33});
    vt.push_back('{3'd5, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 32'h22,        0});
    vt.push_back('{3'd6, 32'h1234_5678, 32'd0,          32'hDEAD_BEEF, 32'h1234_5678, 0});
    vt.push_back('{3'd7, 32'h5555_5555, 32'h3,          32'hDEAD_BEEF, 32'h1234_5678, 0});
    vt.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 33});
    vt.push_back('{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  32'd1,         32'd1,         33});
    vt.push_back('{3'd4, 32'h8000_0001, 32'h8000_0000,  32'd1,         32'd1,         33});
    vt.push_back('{3'd3, 32'h7FFF_FFFF, 32'h8000_0000,  32'h7FFF_FFFF, 32'd0,         33});
    vt.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h7FFF_FFFF, 32'd0,         0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", 64'(bus.EXE_HI), 64'd0);
    chk("reset_lo", 64'(bus.EXE_LO), 64'd0);
    chk("reset_stall", 64'(bus.EXE_MDUStall), 64'd0);
    chk("reset_busy", 64'(bus.MDU_Busy), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      model_op(vt[i].op, vt[i].a, vt[i].b, st);
      op_and_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                   vt[i].hi, vt[i].lo, vt[i].stalls);
    end

    // Flush in RUN cycle 10 kills the divide without touching HI/LO.
    bus.EXE_Valid = 1'b1; bus.EXE_MDUOp = 3'd3;
    bus.EXE_OutA = 32'd1000; bus.EXE_OutB = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    chk("flush_run_busy", 64'(bus.MDU_Busy), 64'd1);
    chk("flush_run_stall_before", 64'(bus.EXE_MDUStall), 64'd1);
    bus.EXEMEM_Flush = 1'b1;
    @(negedge clk);
    chk("flush_run_stall_drop", 64'(bus.EXE_MDUStall), 64'd0);
    @(posedge clk);
    #1;
    bus.EXEMEM_Flush = 1'b0; bus.EXE_Valid = 1'b0; bus.EXE_MDUOp = 3'd0;
    chk("flush_run_idle", 64'(bus.MDU_Busy), 64'd0);
    chk("flush_run_hi", 64'(bus.EXE_HI), 64'(m_hi));
    chk("flush_run_lo", 64'(bus.EXE_LO), 64'(m_lo));
    model_op(3'd4, 32'd9, 32'd4, st);
    op_and_check("after_flush_divu", 3'd4, 32'd9, 32'd4, 32'd1, 32'd2, 33);

    // Flushed MTHI/MTLO and a flushed DIV in IDLE have no effect.
    bus.EXEMEM_Flush = 1'b1; bus.EXE_Valid = 1'b1;
    bus.EXE_MDUOp = 3'd5; bus.EXE_OutA = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.EXE_MDUOp = 3'd6; bus.EXE_OutA = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("flush_mthi_hi", 64'(bus.EXE_HI), 64'd1);
    chk("flush_mtlo_lo", 64'(bus.EXE_LO), 64'd2);
    bus.EXE_MDUOp = 3'd3; bus.EXE_OutB = 32'd5;
    @(negedge clk);
    chk("flush_div_idle_stall", 64'(bus.EXE_MDUStall), 64'd0);
    @(posedge clk);
    #1;
    chk("flush_div_idle_busy", 64'(bus.MDU_Busy), 64'd0);
    bus.EXEMEM_Flush = 1'b0; bus.EXE_Valid = 1'b0; bus.EXE_MDUOp = 3'd0;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ehi, elo;
      int est;
      rop = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      model_op(rop, ra, rb, est);
      ehi = m_hi;
      elo = m_lo;
      op_and_check($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ehi, elo, est);
    end

    // Asynchronous reset in RUN cycle 5 clears everything before the next edge.
    model_op(3'd5, 32'hCAFE_F00D, 32'd0, st);
    op_and_check("pre_reset_mthi", 3'd5, 32'hCAFE_F00D, 32'd0, m_hi, m_lo, 0);
    model_op(3'd6, 32'h0BAD_CAFE, 32'd0, st);
    op_and_check("pre_reset_mtlo", 3'd6, 32'h0BAD_CAFE, 32'd0, m_hi, m_lo, 0);
    bus.EXE_Valid = 1'b1; bus.EXE_MDUOp = 3'd3;
    bus.EXE_OutA = 32'h0001_2345; bus.EXE_OutB = 32'd7;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("run5_busy", 64'(bus.MDU_Busy), 64'd1);
    chk("run5_stall", 64'(bus.EXE_MDUStall), 64'd1);
    #1;
    rst = 1'b0; bus.EXE_Valid = 1'b0; bus.EXE_MDUOp = 3'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    chk("async_rst_stall", 64'(bus.EXE_MDUStall), 64'd0);
    chk("async_rst_busy", 64'(bus.MDU_Busy), 64'd0);
    chk("async_rst_hi", 64'(bus.EXE_HI), 64'd0);
    chk("async_rst_lo", 64'(bus.EXE_LO), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    op_and_check("post_reset_nop", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    model_op(3'd4, 32'd50, 32'd8, st);
    op_and_check("post_reset_divu", 3'd4, 32'd50, 32'd8, 32'd2, 32'd6, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_mdu.md
# exe_mdu

- Multiply/divide unit for the EXE stage.
- Sits beside the ALU and consumes the same forwarded operands (EXE_OutA/EXE_OutB).
- Owns the architectural HI/LO registers and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiplies finish in one cycle. Divides take a 32-iteration restoring sequence and hold the front of the pipeline (PC, IF/ID, ID/EXE) through EXE_MDUStall.

## Interface
Parameters:
- DIV_ITER, 32, number of divide iterations. Equals the data width; not intended to change.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- EXE_MDUOp  in  3  opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- EXE_Valid  in  1  EXE instruction is live (not a bubble).
- EXE_OutA  in  32  forwarded rs value (dividend / multiplicand / MTHI-MTLO source).
- EXE_OutB  in  32  forwarded rt value (divisor / multiplier).
- EXEMEM_Flush  in  1  exception flush; kills the EXE instruction.
- EXE_MDUStall  out  1  front-end hold request.
- EXE_HI  out  32  current HI register (feeds MFHI).
- EXE_LO  out  32  current LO register (feeds MFLO).
- MDU_Busy  out  1  divider FSM not in IDLE.

## Operation
- Reset: HI=0, LO=0, FSM=IDLE, counter=0, EXE_MDUStall=0, MDU_Busy=0.
- An op is "accepted" when EXE_Valid=1, EXEMEM_Flush=0 and the FSM is IDLE.
- MULT/MULTU:
  - Form the 64-bit product combinationally.
  - Write {HI,LO} at the accepting edge.
  - MULT sign-extends both operands; MULTU zero-extends them.
  - No stall.
- MTHI/MTLO: write EXE_OutA into HI or LO at the accepting edge. The other register is unchanged.
- DIV/DIVU uses three FSM states:
  - IDLE -> RUN on acceptance.
    - Latch |A| and |B| (raw values for DIVU).
    - Latch the quotient sign (A[31]^B[31]) and remainder sign (A[31]). Both signs are 0 for DIVU.
    - Latch a divide-by-zero flag (B==0). Clear remainder and counter.
  - RUN, one restoring step per cycle:
    - Shift {rem,quo} left by 1.
    - Trial-subtract the divisor from rem.
    - If no borrow, keep the difference and set the quotient LSB.
    - Increment the counter. After the step with counter==DIV_ITER-1, go to DONE.
  - DONE, one cycle:
    - Apply the signs by two's complement negation.
    - Write LO=quotient and HI=remainder at the DONE edge, unless the divide-by-zero flag is set (then HI/LO are unchanged).
    - Return to IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This is the natural 32-bit wrap with no trap.
- EXE_MDUStall (combinational) = ~EXEMEM_Flush & ((IDLE & EXE_Valid & op∈{DIV,DIVU}) | RUN).
- Flush:
  - EXEMEM_Flush=1 in any state forces the FSM to IDLE at the next edge.
  - No HI/LO write happens that cycle; this includes DONE and any accepted MULT/MT*.
  - EXE_MDUStall drops in the same cycle so the exception vector can load.
- Reset mid-divide: everything returns to reset values immediately (asynchronous). HI/LO are cleared.
- MDU_Busy = (FSM != IDLE).

## Timing
- MULT/MT*: HI/LO are visible on EXE_HI/EXE_LO the cycle after acceptance. An MFHI/MFLO in the next EXE cycle reads the new value with no bypass.
- DIV latency:
  - Acceptance cycle T: stall=1.
  - Cycles T+1..T+32 (RUN): stall=1.
  - Cycle T+33 (DONE): stall=0 and the instruction advances.
  - HI/LO are valid from T+34.
  - Stall is high for exactly 33 cycles.
- The ID/EXE register advances on every edge where EXE_MDUStall=0. The DIV therefore leaves EXE at the DONE edge, and the FSM never re-accepts the same instruction.
- A back-to-back DIV arriving at T+34 is accepted normally, since the FSM is already IDLE.
- No input is sampled during RUN. The operands are the latched copies.

## Test plan
- Reset, then MULT A=0xFFFFFFFD B=7 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFEB, stall never asserted. Then MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7) B=2 -> stall high exactly 33 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with DIVU A=100 B=7 -> LO=14, HI=2.
- DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU B=0 with preset HI=0x11, LO=0x22 -> 33-cycle stall, HI/LO stay 0x11/0x22.
- Start DIV, assert EXEMEM_Flush in RUN cycle 10 -> stall falls that cycle, FSM IDLE next edge, HI/LO unchanged. An immediate DIVU 9/4 then gives LO=2, HI=1.
- MTHI 0xDEADBEEF, then MTLO 0x12345678 on consecutive cycles -> HI=0xDEADBEEF, LO=0x12345678. Same ops with EXEMEM_Flush=1 -> no change.
- Deassert rst (drive low) during RUN cycle 5 -> stall, Busy, HI and LO go to 0 immediately. After release, the FSM is IDLE and a NOP keeps stall=0.
